conv_array_core: RTL and testbench

CONV_ARRAY_CORE -- requirements
Module: conv_array_core

---
 rtl/definition.sv | 8 +
 rtl/conv_col_mac.sv | 35 +++
 rtl/conv_array_core.sv | 97 +++++++++
 tb/tb_conv_array_core.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/definition.sv
// Shared constants and types for the convolution array: element width and mode-bit layout.
package definition;
  localparam int width       = 8;
  localparam int MODE_SIGNED = 0;
  localparam int MODE_RELU   = 1;

  typedef logic [1:0] mode_t;
endpackage

// File: rtl/conv_col_mac.sv
// One output row's KS-tap column dot product; purely combinational, no flow control.
module conv_col_mac
  import definition::*;
#(
  parameter int KS    = 3,
  parameter int W     = width,
  parameter int ACC_W = 2*W + $clog2(KS*KS) + 1
) (
  input  logic                    is_signed,
  input  logic [KS-1:0][W-1:0]    px,
  input  logic [KS-1:0][W-1:0]    tap,
  output logic signed [ACC_W-1:0] dot
);

  localparam int EXT = ACC_W - 2*W - 2;

  logic signed [W:0]     a;
  logic signed [W:0]     b;
  logic signed [2*W+1:0] p;

  // One extra bit per operand lets a single signed multiplier serve both modes.
  always_comb begin
    a   = '0;
    b   = '0;
    p   = '0;
    dot = '0;
    for (int k = 0; k < KS; k++) begin
      a   = $signed({is_signed & px[k][W-1], px[k]});
      b   = $signed({is_signed & tap[k][W-1], tap[k]});
      p   = a * b;
      dot = dot + $signed({{EXT{p[2*W+1]}}, p});
    end
  end

endmodule

// File: rtl/conv_array_core.sv
// KSxKS convolution over column beats; result registered 1 cycle after the last beat.
// Holds the result until o_ready; stalls only the next window's final beat while a result is pending.
module conv_array_core
  import definition::*;
#(
  parameter int  KS    = 3,
  parameter int  NROW  = 4,
  parameter int  W     = width,
  localparam int NOUT  = NROW - KS + 1,
  localparam int ACC_W = 2*W + $clog2(KS*KS) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 i_mode,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic [NROW-1:0][W-1:0]     i_row,
  input  logic [KS-1:0][W-1:0]       i_f,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [NOUT-1:0][2*W-1:0]   o_sum
);

  localparam int              CW   = $clog2(KS);
  localparam logic [CW-1:0]   LAST = CW'(KS - 1);
  localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-2*W+1){1'b0}}, {(2*W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-2*W+1){1'b1}}, {(2*W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] UMAX = {{(ACC_W-2*W){1'b0}}, {(2*W){1'b1}}};

  logic [CW-1:0]            col;
  mode_t                    mode_q;
  mode_t                    win_mode;
  logic                     accept;
  logic                     first;
  logic                     last;
  logic signed [ACC_W-1:0]  acc     [NOUT];
  logic signed [ACC_W-1:0]  dot     [NOUT];
  logic signed [ACC_W-1:0]  acc_nxt [NOUT];

  function automatic logic [2*W-1:0] sat_relu(input logic signed [ACC_W-1:0] v, input mode_t m);
    logic signed [ACC_W-1:0] x;
    logic [2*W-1:0]          r;
    x = v;
    if (m[MODE_RELU] && x < 0) x = '0;
    if (m[MODE_SIGNED]) begin
      if (x > SMAX)      r = SMAX[2*W-1:0];
      else if (x < SMIN) r = SMIN[2*W-1:0];
      else               r = x[2*W-1:0];
    end else begin
      if (x > UMAX)      r = UMAX[2*W-1:0];
      else if (x < 0)    r = '0;
      else               r = x[2*W-1:0];
    end
    return r;
  endfunction

  assign i_ready  = !(o_valid && !o_ready && col == LAST);
  assign accept   = i_valid && i_ready;
  assign first    = (col == '0);
  assign last     = (col == LAST);
  // Column 0 uses the live mode; later columns use the value latched at column 0.
  assign win_mode = first ? mode_t'(i_mode) : mode_q;

  for (genvar r = 0; r < NOUT; r++) begin : g_row
    conv_col_mac #(.KS(KS), .W(W), .ACC_W(ACC_W)) u_mac (
      .is_signed (win_mode[MODE_SIGNED]),
      .px        (i_row[r +: KS]),
      .tap       (i_f),
      .dot       (dot[r])
    );
    assign acc_nxt[r] = first ? dot[r] : acc[r] + dot[r];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col     <= '0;
      mode_q  <= '0;
      o_valid <= 1'b0;
      o_sum   <= '0;
      for (int r = 0; r < NOUT; r++) acc[r] <= '0;
    end else begin
      if (o_valid && o_ready) o_valid <= 1'b0;
      if (accept) begin
        for (int r = 0; r < NOUT; r++) acc[r] <= acc_nxt[r];
        if (first) mode_q <= i_mode;
        if (last) begin
          col     <= '0;
          o_valid <= 1'b1;
          for (int r = 0; r < NOUT; r++) o_sum[r] <= sat_relu(acc_nxt[r], win_mode);
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_array_core.sv
// Directed bench for conv_array_core at KS=3, NROW=4, W=8.
module tb_conv_array_core;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       i_mode;
  logic             i_valid;
  logic             i_ready;
  logic [3:0][7:0]  i_row;
  logic [2:0][7:0]  i_f;
  logic             o_valid;
  logic             o_ready;
  logic [1:0][15:0] o_sum;

  int total = 0;
  int bad   = 0;

  localparam logic [23:0] F_A1 = {8'd7, 8'd4, 8'd1};
  localparam logic [23:0] F_A2 = {8'd8, 8'd5, 8'd2};
  localparam logic [23:0] F_A3 = {8'd9, 8'd6, 8'd3};

  conv_array_core #(.KS(3), .NROW(4), .W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_mode  (i_mode),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_row   (i_row),
    .i_f     (i_f),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_sum   (o_sum)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rows(input logic [7:0] v);
    return {4{v}};
  endfunction

  function automatic logic [23:0] filt(input logic [7:0] v);
    return {3{v}};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] r, input logic [23:0] f, input logic [1:0] m);
    i_row   = r;
    i_f     = f;
    i_mode  = m;
    i_valid = 1'b1;
    chk("beat_ready", {31'b0, i_ready}, 32'd1);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] e0, input logic [15:0] e1);
    chk({tag, "_vld"},  {31'b0, o_valid}, 32'd1);
    chk({tag, "_sum0"}, {16'b0, o_sum[0]}, {16'b0, e0});
    chk({tag, "_sum1"}, {16'b0, o_sum[1]}, {16'b0, e1});
    tick();
    chk({tag, "_one_cycle"}, {31'b0, o_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; i_mode = '0; i_valid = 1'b0; o_ready = 1'b1; i_row = '0; i_f = '0;
    tick(); tick();
    chk("rst_vld", {31'b0, o_valid}, 32'd0);
    chk("rst_sum", o_sum, 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_ready", {31'b0, i_ready}, 32'd1);

    // basic unsigned window: 12 + 30 + 54
    beat(rows(8'd1), F_A1, 2'b00);
    chk("basic_mid", {31'b0, o_valid}, 32'd0);
    beat(rows(8'd2), F_A2, 2'b00);
    beat(rows(8'd3), F_A3, 2'b00);
    expect_out("basic", 16'd96, 16'd96);

    // distinct rows per position: row0 = 3*(1+20+300), row1 = 3*(2+30+400)
    repeat (3) beat({8'd4, 8'd3, 8'd2, 8'd1}, {8'd100, 8'd10, 8'd1}, 2'b00);
    expect_out("rowidx", 16'd963, 16'd1296);

    // gapped valid pattern 1,0,0,1,0,1
    beat(rows(8'd1), F_A1, 2'b00);
    tick(); tick();
    beat(rows(8'd2), F_A2, 2'b00);
    tick();
    chk("gap_mid", {31'b0, o_valid}, 32'd0);
    beat(rows(8'd3), F_A3, 2'b00);
    expect_out("gap", 16'd96, 16'd96);

    // signed with ReLU, then signed without ReLU with a mid-window mode change ignored
    repeat (3) beat(rows(8'd5), filt(8'hFF), 2'b11);
    expect_out("relu", 16'd0, 16'd0);
    beat(rows(8'd5), filt(8'hFF), 2'b01);
    beat(rows(8'd5), filt(8'hFF), 2'b11);
    beat(rows(8'd5), filt(8'hFF), 2'b11);
    expect_out("neg45", 16'hFFD3, 16'hFFD3);

    // saturation: +147456 -> 7FFF, -146304 -> 8000, unsigned 585225 -> FFFF
    repeat (3) beat(rows(8'h80), filt(8'h80), 2'b01);
    expect_out("sat_pos", 16'h7FFF, 16'h7FFF);
    repeat (3) beat(rows(8'h80), filt(8'h7F), 2'b01);
    expect_out("sat_neg", 16'h8000, 16'h8000);
    repeat (3) beat(rows(8'hFF), filt(8'hFF), 2'b00);
    expect_out("sat_uns", 16'hFFFF, 16'hFFFF);

    // backpressure: two windows back to back with o_ready low
    o_ready = 1'b0;
    beat(rows(8'd1), F_A1, 2'b00);
    beat(rows(8'd2), F_A2, 2'b00);
    beat(rows(8'd3), F_A3, 2'b00);
    chk("bp_a_vld", {31'b0, o_valid}, 32'd1);
    chk("bp_a_sum", {16'b0, o_sum[0]}, 32'd96);
    beat(rows(8'd1), filt(8'd1), 2'b00);
    beat(rows(8'd1), filt(8'd1), 2'b00);
    chk("bp_stall", {31'b0, i_ready}, 32'd0);
    i_row = rows(8'd1); i_f = filt(8'd1); i_mode = 2'b00; i_valid = 1'b1;
    tick(); tick();
    chk("bp_stall_held", {31'b0, i_ready}, 32'd0);
    chk("bp_hold_vld", {31'b0, o_valid}, 32'd1);
    chk("bp_hold_sum0", {16'b0, o_sum[0]}, 32'd96);
    chk("bp_hold_sum1", {16'b0, o_sum[1]}, 32'd96);
    o_ready = 1'b1;
    #1;
    chk("bp_release", {31'b0, i_ready}, 32'd1);
    tick();
    i_valid = 1'b0;
    expect_out("bp_b", 16'd9, 16'd9);

    // reset mid-window drops both the pending result and the partial window
    o_ready = 1'b0;
    repeat (3) beat(rows(8'd2), filt(8'd2), 2'b00);
    chk("pend_sum", {16'b0, o_sum[0]}, 32'd36);
    beat(rows(8'd9), filt(8'd9), 2'b00);
    beat(rows(8'd9), filt(8'd9), 2'b00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_vld", {31'b0, o_valid}, 32'd0);
    chk("mrst_sum", o_sum, 32'd0);
    chk("mrst_ready", {31'b0, i_ready}, 32'd1);
    o_ready = 1'b1;
    repeat (3) beat(rows(8'd1), filt(8'd1), 2'b00);
    expect_out("post_rst", 16'd9, 16'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
